// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the controller state encoding, frame-length limits and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_CLEAR    = 2'd3
  } rx_ctrl_state_t;

  localparam int DLEN_MIN   = 5;
  localparam int DLEN_MAX   = 8;
  localparam int OVERSAMPLE = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

  // Out-of-range data lengths fall back to the widest legal frame.
  function automatic logic [3:0] legal_dlen(input logic [3:0] len);
    logic [3:0] res;
    if ((len < 4'(DLEN_MIN)) || (len > 4'(DLEN_MAX))) begin
      res = 4'(DLEN_MAX);
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO shared by the UART RX and TX controllers.
// A pop frees a slot before the push is judged, so push+pop while full always succeeds.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags and head word, all taken from registered state
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: owns the frame config, arms the UART RX core, buffers
// captured frames with their error flag and reports overrun and idle-line timeout.
module uart_rx_ctrl #(
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cfg_wr,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop2,
  input  logic [3:0] cfg_data_len,
  input  logic       rx,
  input  logic       core_done,
  input  logic       core_err,
  input  logic [7:0] core_data,
  output logic       core_start,
  output logic       core_rst_n,
  output logic       core_parity_en,
  output logic       core_parity_type,
  output logic       core_stop2,
  output logic [3:0] core_data_len,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       idle_to,
  output logic       cfg_err
);

  import uart_pkg::*;

  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TW       = $clog2(TO_LIMIT) + 1;

  rx_ctrl_state_t  state_r;
  logic            done_prev_r;
  logic            rx_prev_r;
  logic [TW-1:0]   to_cnt_r;
  rx_entry_t       push_entry_s;
  rx_entry_t       head_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic            done_rise_s;
  logic            rx_fall_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  // Handshake, edge detection and FIFO head unpacking
  always_comb begin
    push_s            = (state_r == ST_CAPTURE);
    m_valid           = !fifo_empty_s;
    pop_s             = m_valid && m_ready;
    drop_s            = push_s && fifo_full_s && !m_ready;
    done_rise_s       = core_done && !done_prev_r;
    rx_fall_s         = rx_prev_r && !rx;
    push_entry_s.err  = core_err;
    push_entry_s.data = core_data;
    m_data            = head_s.data;
    m_err             = head_s.err;
  end

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (rx_clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Control FSM with registered core-side and config outputs
  always_ff @(posedge rx_clk) begin
    if (!rst) begin
      state_r          <= ST_DISABLED;
      core_start       <= 1'b0;
      core_rst_n       <= 1'b1;
      done_prev_r      <= 1'b0;
      core_parity_en   <= 1'b0;
      core_parity_type <= 1'b0;
      core_stop2       <= 1'b0;
      core_data_len    <= 4'(DLEN_MAX);
      cfg_err          <= 1'b0;
    end else begin
      done_prev_r <= core_done;
      cfg_err     <= cfg_wr && (state_r != ST_DISABLED);
      core_rst_n  <= 1'b1;
      case (state_r)
        ST_DISABLED: begin
          if (cfg_wr) begin
            core_parity_en   <= cfg_parity_en;
            core_parity_type <= cfg_parity_type;
            core_stop2       <= cfg_stop2;
            core_data_len    <= legal_dlen(cfg_data_len);
          end
          if (en) begin
            state_r    <= ST_ARMED;
            core_start <= 1'b1;
          end else begin
            core_start <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (done_rise_s) begin
            state_r    <= ST_CAPTURE;
            core_start <= 1'b1;
          end else if (!en && !core_done) begin
            state_r    <= ST_DISABLED;
            core_start <= 1'b0;
          end else begin
            core_start <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (core_err) begin
            state_r    <= ST_CLEAR;
            core_start <= 1'b0;
            core_rst_n <= 1'b0;
          end else begin
            state_r    <= ST_ARMED;
            core_start <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Treat whatever is left of the done level as already seen.
          done_prev_r <= 1'b1;
          if (en) begin
            state_r    <= ST_ARMED;
            core_start <= 1'b1;
          end else begin
            state_r    <= ST_DISABLED;
            core_start <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_DISABLED;
          core_start <= 1'b0;
        end
      endcase
    end
  end

  // Overrun flag and idle-line timeout
  always_ff @(posedge rx_clk) begin
    if (!rst) begin
      overrun   <= 1'b0;
      idle_to   <= 1'b0;
      rx_prev_r <= 1'b1;
      to_cnt_r  <= {TW{1'b0}};
    end else begin
      rx_prev_r <= rx;
      idle_to   <= 1'b0;
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (rx_fall_s || push_s) begin
        to_cnt_r <= {TW{1'b0}};
      end else if (!fifo_empty_s && (state_r == ST_ARMED) && (to_cnt_r != TW'(TO_LIMIT))) begin
        to_cnt_r <= to_cnt_r + TW'(1);
        idle_to  <= (to_cnt_r == TW'(TO_LIMIT - 1));
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: emulates the RX core's done/err/data outputs
// and checks popped FIFO words against a scoreboard queue.
module tb_uart_rx_ctrl;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_wr = 1'b0;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic [3:0] cfg_data_len = 4'd8;
  logic       rx = 1'b1;
  logic       core_done = 1'b0;
  logic       core_err = 1'b0;
  logic [7:0] core_data = 8'h00;
  logic       core_start;
  logic       core_rst_n;
  logic       core_parity_en;
  logic       core_parity_type;
  logic       core_stop2;
  logic [3:0] core_data_len;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_err;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic       idle_to;
  logic       cfg_err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         rst_lo_cnt = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_v;

  uart_rx_ctrl #(
    .DEPTH        (4),
    .TIMEOUT_BITS (4)
  ) dut (
    .rx_clk           (rx_clk),
    .rst              (rst),
    .en               (en),
    .cfg_wr           (cfg_wr),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_parity_type  (cfg_parity_type),
    .cfg_stop2        (cfg_stop2),
    .cfg_data_len     (cfg_data_len),
    .rx               (rx),
    .core_done        (core_done),
    .core_err         (core_err),
    .core_data        (core_data),
    .core_start       (core_start),
    .core_rst_n       (core_rst_n),
    .core_parity_en   (core_parity_en),
    .core_parity_type (core_parity_type),
    .core_stop2       (core_stop2),
    .core_data_len    (core_data_len),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_err            (m_err),
    .overrun          (overrun),
    .ovr_clr          (ovr_clr),
    .idle_to          (idle_to),
    .cfg_err          (cfg_err)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops are compared against the scoreboard; the core-reset pulse is measured here too.
  always @(negedge rx_clk) begin
    #1;
    if (rst && m_valid && m_ready) begin
      check_val("sb_nonempty_on_pop", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        check_val("sb_data", 32'(m_data), 32'(exp_v[7:0]));
        check_val("sb_err", 32'(m_err), 32'(exp_v[8]));
      end
    end
    if (rst && !core_rst_n) begin
      rst_lo_cnt++;
      check_val("start_in_clear", 32'(core_start), 32'd0);
    end
  end

  task automatic configure(input logic pe, input logic pt, input logic s2, input logic [3:0] len);
    @(negedge rx_clk);
    en = 1'b0;
    repeat (2) @(negedge rx_clk);
    cfg_parity_en   = pe;
    cfg_parity_type = pt;
    cfg_stop2       = s2;
    cfg_data_len    = len;
    cfg_wr          = 1'b1;
    @(negedge rx_clk);
    cfg_wr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input bit store, input bit pulse_ready);
    if (store) sb.push_back({e, d});
    @(negedge rx_clk);
    core_data = d;
    core_err  = e;
    core_done = 1'b1;
    @(negedge rx_clk);
    if (pulse_ready) m_ready = 1'b1;
    @(negedge rx_clk);
    if (pulse_ready) m_ready = 1'b0;
    repeat (14) @(negedge rx_clk);
    core_done = 1'b0;
    core_err  = 1'b0;
    repeat (3) @(negedge rx_clk);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    m_ready = 1'b1;
    while (sb.size() != 0 && k < 40) begin
      @(negedge rx_clk);
      k++;
    end
    @(negedge rx_clk);
    m_ready = 1'b0;
    @(negedge rx_clk);
    check_val(tag, 32'(sb.size()), 32'd0);
    check_val("empty_after_drain", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    repeat (3) @(negedge rx_clk);
    check_val("rst_core_start", 32'(core_start), 32'd0);
    check_val("rst_core_rst_n", 32'(core_rst_n), 32'd1);
    check_val("rst_parity_en", 32'(core_parity_en), 32'd0);
    check_val("rst_parity_type", 32'(core_parity_type), 32'd0);
    check_val("rst_stop2", 32'(core_stop2), 32'd0);
    check_val("rst_data_len", 32'(core_data_len), 32'd8);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'd0);
    check_val("rst_m_err", 32'(m_err), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_idle_to", 32'(idle_to), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b1;

    // Config gating: illegal length, 7N1, then a write while armed
    configure(1'b0, 1'b0, 1'b0, 4'd3);
    check_val("cfg_illegal_len", 32'(core_data_len), 32'd8);
    configure(1'b0, 1'b0, 1'b0, 4'd7);
    check_val("cfg_len7", 32'(core_data_len), 32'd7);
    check_val("start_before_en", 32'(core_start), 32'd0);
    en = 1'b1;
    @(negedge rx_clk);
    check_val("start_after_en", 32'(core_start), 32'd1);
    cfg_parity_en = 1'b1;
    cfg_data_len  = 4'd5;
    cfg_wr        = 1'b1;
    @(negedge rx_clk);
    cfg_wr = 1'b0;
    check_val("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check_val("cfg_len_kept", 32'(core_data_len), 32'd7);
    check_val("cfg_par_kept", 32'(core_parity_en), 32'd0);
    @(negedge rx_clk);
    check_val("cfg_err_one_cycle", 32'(cfg_err), 32'd0);

    // Good frame 0xA5 at 8N1 with capture latency and held done level
    configure(1'b0, 1'b0, 1'b0, 4'd8);
    check_val("start_disabled", 32'(core_start), 32'd0);
    check_val("cfg_len8", 32'(core_data_len), 32'd8);
    en = 1'b1;
    @(negedge rx_clk);
    sb.push_back({1'b0, 8'hA5});
    core_data = 8'hA5;
    core_err  = 1'b0;
    core_done = 1'b1;
    @(negedge rx_clk);
    check_val("lat_push_cycle", 32'(m_valid), 32'd0);
    @(negedge rx_clk);
    check_val("lat_valid", 32'(m_valid), 32'd1);
    check_val("good_data", 32'(m_data), 32'hA5);
    check_val("good_err", 32'(m_err), 32'd0);
    repeat (14) @(negedge rx_clk);
    core_done = 1'b0;
    repeat (3) @(negedge rx_clk);
    m_ready = 1'b1;
    @(negedge rx_clk);
    m_ready = 1'b0;
    @(negedge rx_clk);
    check_val("no_second_push", 32'(m_valid), 32'd0);

    // Parity error frame followed by a good frame
    configure(1'b1, 1'b0, 1'b0, 4'd8);
    check_val("cfg_parity_en", 32'(core_parity_en), 32'd1);
    en = 1'b1;
    @(negedge rx_clk);
    m_ready    = 1'b1;
    rst_lo_cnt = 0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_val("core_rst_pulse_len", 32'(rst_lo_cnt), 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_val("core_rst_no_pulse", 32'(rst_lo_cnt), 32'd1);
    check_val("par_sb_drained", 32'(sb.size()), 32'd0);
    m_ready = 1'b0;

    // Overrun: five frames into a four-deep FIFO, then clear
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, (i < 4), 1'b0);
    end
    check_val("overrun_set", 32'(overrun), 32'd1);
    check_val("full_valid", 32'(m_valid), 32'd1);
    @(negedge rx_clk);
    ovr_clr = 1'b1;
    @(negedge rx_clk);
    ovr_clr = 1'b0;
    check_val("overrun_cleared", 32'(overrun), 32'd0);

    // Push and pop in the same cycle while full
    send_frame(8'h20, 1'b0, 1'b1, 1'b1);
    check_val("full_pushpop_no_ovr", 32'(overrun), 32'd0);
    drain("full_pushpop_drain");

    // Idle timeout 64 cycles after the push
    sb.push_back({1'b0, 8'h33});
    fork
      begin
        @(negedge rx_clk);
        core_data = 8'h33;
        core_done = 1'b1;
        repeat (16) @(negedge rx_clk);
        core_done = 1'b0;
      end
      begin
        @(negedge rx_clk);
        repeat (2) @(posedge rx_clk);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
          @(posedge rx_clk);
          #1;
          n++;
          seen = idle_to;
        end
        check_val("idle_to_latency", 32'(n), 32'd64);
        @(posedge rx_clk);
        #1;
        check_val("idle_to_pulse_width", 32'(idle_to), 32'd0);
      end
    join
    drain("idle_drain");

    // Falling edge on rx before the limit suppresses the pulse
    sb.push_back({1'b0, 8'h44});
    fork
      begin
        @(negedge rx_clk);
        core_data = 8'h44;
        core_done = 1'b1;
        repeat (16) @(negedge rx_clk);
        core_done = 1'b0;
      end
      begin
        @(negedge rx_clk);
        repeat (2) @(posedge rx_clk);
        seen = 1'b0;
        for (int i = 0; i < 90; i++) begin
          @(posedge rx_clk);
          #1;
          if (idle_to) seen = 1'b1;
          if (i == 40) rx = 1'b0;
          if (i == 41) rx = 1'b1;
        end
        check_val("idle_to_suppressed", 32'(seen), 32'd0);
      end
    join
    drain("rxfall_drain");

    check_val("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
